// File: rtl/band8_distributor.sv
// Single-slot distributor: accepts a 4-bit word, delivers it into one of eight registered
// output channels with full/ack handshake. Define BAND8_DISTRIBUTOR_AUTO_EN for round-robin routing.
module band8_distributor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] ctrl,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] out4,
  output logic [3:0] out5,
  output logic [3:0] out6,
  output logic [3:0] out7,
  output logic [7:0] full,
  input  logic [7:0] ack,
  output logic       frame_done
);

  // state   | meaning
  // IDLE    | ready to capture a word into hold
  // DELIVER | hold waits for its channel to be free (or acked this cycle)
  typedef enum logic {IDLE = 1'b0, DELIVER = 1'b1} state_t;

  state_t     state, state_next;
  logic [3:0] hold;
  logic [2:0] hold_ch;
  logic [2:0] dest;
  logic [3:0] out_q [8];
  logic [7:0] full_next;
  logic       deliver;
  logic       accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // in_ready depends on state only, so no combinational in_valid -> in_ready path
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    deliver    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = DELIVER;
        end
      end
      DELIVER: begin
        if (!full[hold_ch] || ack[hold_ch]) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A same-cycle delivery wins over an ack on the same channel
  always_comb begin
    full_next = full & ~ack;
    if (deliver) full_next[hold_ch] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold    <= 4'h0;
      hold_ch <= 3'd0;
      full    <= 8'h00;
      for (int i = 0; i < 8; i++) out_q[i] <= 4'h0;
    end else begin
      if (accept) begin
        hold    <= in;
        hold_ch <= dest;
      end
      full <= full_next;
      for (int i = 0; i < 8; i++)
        if (deliver && (hold_ch == 3'(i))) out_q[i] <= hold;
    end
  end

  assign out0 = out_q[0];
  assign out1 = out_q[1];
  assign out2 = out_q[2];
  assign out3 = out_q[3];
  assign out4 = out_q[4];
  assign out5 = out_q[5];
  assign out6 = out_q[6];
  assign out7 = out_q[7];

`ifdef BAND8_DISTRIBUTOR_AUTO_EN
  logic [2:0] ptr;
  logic [2:0] unused_ctrl;

  assign unused_ctrl = ctrl;
  assign dest        = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 3'd0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= deliver && (hold_ch == 3'd7);
      if (deliver) ptr <= ptr + 3'd1;
    end
  end
`else
  assign dest       = ctrl;
  assign frame_done = 1'b0;
`endif

endmodule
